// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Moore-style control FSM for a multi-cycle RV32I datapath. The FSM walks
//   FETCH -> DECODE -> (per-class execute/memory states) -> write-back and back
//   to FETCH. It drives datapath muxes, memory strobes and register-file
//   writes. It also flags undecodable opcodes and reserved branch funct3 codes.
//
// Ports
//   clk          in   1   sole clock, rising edge
//   rst          in   1   asynchronous active-high reset (outputs forced to 0)
//   instr        in  32   IR contents (op=[6:0], funct3=[14:12], funct7b5=[30])
//   mem_ready    in   1   memory access complete (FETCH/MEMREAD/MEMWRITE only)
//   zero/lt/ltu  in   1   ALU compare flags used in BRANCH
//   PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite   out 1
//   illegal      out  1   undecodable op (DECODE) or reserved branch funct3
//   instr_done   out  1   one-cycle pulse in the final state of an instruction
//   ResultSrc    out  2   00 ALUOut, 01 Data, 10 ALUResult
//   ALUSrcA      out  2   00 PC, 01 OldPC, 10 rs1, 11 zero
//   ALUSrcB      out  2   00 rs2, 01 ImmOp, 10 const 4
//   ALUOp        out  2   00 add, 01 compare, 10 funct-decoded
//   IMMSrc       out  3   000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt
//   state        out  4   current FSM state (debug)
//
// Configuration
//   SHAMT_IMM_EN  when defined, OP-IMM shifts (funct3 001/101) select the
//                 shamt immediate format (IMMSrc=101) instead of I (000).
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        illegal,
  output logic        instr_done,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [2:0]  IMMSrc,
  output logic [3:0]  state
);

  // State encodings.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_UPPER    = 4'd11;
  localparam logic [3:0] S_JALR     = 4'd12;

  // RV32I base opcodes.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate format selects.
  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_J     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;

  // Mux select encodings.
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] A_PC       = 2'b00;
  localparam logic [1:0] A_OLDPC    = 2'b01;
  localparam logic [1:0] A_RS1      = 2'b10;
  localparam logic [1:0] A_ZERO     = 2'b11;
  localparam logic [1:0] B_RS2      = 2'b00;
  localparam logic [1:0] B_IMM      = 2'b01;
  localparam logic [1:0] B_FOUR     = 2'b10;
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_CMP    = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;

  // Fields not used by control are folded here so they read as intentionally
  // unused. funct7b5 is carried for ALU decode done elsewhere.
  logic unused_instr_bits;

  logic [3:0] dec_target;
  logic       dec_illegal;
  logic [2:0] imm_sel;
  logic       br_taken;
  logic       br_bad;

  assign op                = instr[6:0];
  assign funct3            = instr[14:12];
  assign funct7b5          = instr[30];
  assign unused_instr_bits = ^{instr[31], funct7b5, instr[29:15], instr[11:7]};
  assign state             = state_q;

  // ---------------------------------------------------------------------------
  // DECODE dispatch: target state and legality of the opcode.
  // ---------------------------------------------------------------------------
  always_comb begin
    dec_target  = S_FETCH;
    dec_illegal = 1'b0;
    case (op)
      OP_LOAD, OP_STORE: dec_target = S_MEMADR;
      OP_REG:            dec_target = S_EXECR;
      OP_IMM:            dec_target = S_EXECI;
      OP_BRANCH:         dec_target = S_BRANCH;
      OP_JAL:            dec_target = S_JAL;
      OP_JALR:           dec_target = S_JALR;
      OP_LUI, OP_AUIPC:  dec_target = S_UPPER;
      default:           dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate format, decoded from the opcode.
  // ---------------------------------------------------------------------------
  always_comb begin
    imm_sel = IMM_I;
    case (op)
      OP_STORE:         imm_sel = IMM_S;
      OP_BRANCH:        imm_sel = IMM_B;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      OP_JAL:           imm_sel = IMM_J;
`ifdef SHAMT_IMM_EN
      OP_IMM:           if (funct3 == 3'b001 || funct3 == 3'b101) imm_sel = IMM_SHAMT;
`endif
      default:          imm_sel = IMM_I;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Branch condition from ALU flags; funct3 010/011 are reserved.
  // ---------------------------------------------------------------------------
  always_comb begin
    br_taken = 1'b0;
    br_bad   = 1'b0;
    case (funct3)
      3'b000:  br_taken = zero;
      3'b001:  br_taken = ~zero;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = ~ltu;
      default: br_bad   = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Unused codes 13-15 fall back to FETCH.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   state_d = dec_target;
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_UPPER:    state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Output decode. Everything defaults to 0. Reset gates the whole block so
  // input-dependent outputs such as IRWrite stay low while rst is held.
  // ---------------------------------------------------------------------------
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    illegal    = 1'b0;
    instr_done = 1'b0;
    ResultSrc  = '0;
    ALUSrcA    = '0;
    ALUSrcB    = '0;
    ALUOp      = '0;
    IMMSrc     = '0;
    if (!rst) begin
      if (state_q != S_FETCH) IMMSrc = imm_sel;
      case (state_q)
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcA   = A_PC;
          ALUSrcB   = B_FOUR;
          ResultSrc = RES_ALURES;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
        end
        S_DECODE: begin
          ALUSrcA = A_OLDPC;
          ALUSrcB = B_IMM;
          illegal = dec_illegal;
        end
        S_MEMADR: begin
          ALUSrcA = A_RS1;
          ALUSrcB = B_IMM;
        end
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc  = RES_DATA;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc     = 1'b1;
          MemWrite   = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECR: begin
          ALUSrcA = A_RS1;
          ALUSrcB = B_RS2;
          ALUOp   = ALU_FUNCT;
        end
        S_EXECI: begin
          ALUSrcA = A_RS1;
          ALUSrcB = B_IMM;
          ALUOp   = ALU_FUNCT;
        end
        S_ALUWB: begin
          ResultSrc  = RES_ALUOUT;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA    = A_RS1;
          ALUSrcB    = B_RS2;
          ALUOp      = ALU_CMP;
          ResultSrc  = RES_ALUOUT;
          PCWrite    = br_taken & ~br_bad;
          illegal    = br_bad;
          instr_done = ~br_bad;
        end
        S_JALR: begin
          ALUSrcA = A_RS1;
          ALUSrcB = B_IMM;
        end
        S_JAL: begin
          ALUSrcA   = A_OLDPC;
          ALUSrcB   = B_FOUR;
          ResultSrc = RES_ALUOUT;
          PCWrite   = 1'b1;
        end
        S_UPPER: begin
          ALUSrcB = B_IMM;
          ALUSrcA = (op == OP_LUI) ? A_ZERO : A_OLDPC;
        end
        default: ;
      endcase
    end
  end

  // ALUOp add encoding is the default value of ALUOp and needs no explicit arm.
  logic unused_alu_add;
  assign unused_alu_add = ^ALU_ADD;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port instr, input, 32, IR contents; op=instr[6:0], funct3=instr[14:12], funct7b5=instr[30].
REQ-004 SHALL have inputs mem_ready (1, memory access complete), zero, lt, ltu (1 each, ALU compare flags).
REQ-005 SHALL have 1-bit outputs PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, illegal, instr_done.
REQ-006 SHALL have 2-bit outputs ResultSrc (00 ALUOut, 01 Data, 10 ALUResult), ALUSrcA (00 PC, 01 OldPC, 10 rs1, 11 zero), ALUSrcB (00 rs2, 01 ImmOp, 10 const 4), ALUOp (00 add, 01 compare, 10 funct-decoded).
REQ-007 SHALL have output IMMSrc, 3, sign-extender format select (000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt).
REQ-008 SHALL have output state, 4, current FSM state encoding (debug).

Function
REQ-009 SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, UPPER=11, JALR=12; codes 13-15 return to FETCH next cycle.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 FETCH: MemRead=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; IRWrite=PCWrite=mem_ready; stay until mem_ready=1, then DECODE.
REQ-012 DECODE: ALUSrcA=01, ALUSrcB=01; next by op: 0000011/0100011 MEMADR, 0110011 EXECR, 0010011 EXECI, 1100011 BRANCH, 1101111 JAL, 1100111 JALR, 0110111/0010111 UPPER; any other op: illegal=1 one cycle, next FETCH.
REQ-013 MEMADR: ALUSrcA=10, ALUSrcB=01; next MEMREAD for load, MEMWRITE for store.
REQ-014 MEMREAD: AdrSrc=1, MemRead=1; hold until mem_ready, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1, next FETCH.
REQ-015 MEMWRITE: AdrSrc=1, MemWrite=1; hold until mem_ready, then FETCH.
REQ-016 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both next ALUWB.
REQ-017 ALUWB: ResultSrc=00, RegWrite=1, next FETCH.
REQ-018 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=taken; taken per funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu; funct3 010/011 not taken and illegal=1; next FETCH.
REQ-019 JALR: ALUSrcA=10, ALUSrcB=01, next JAL. JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, next ALUWB.
REQ-020 UPPER: ALUSrcB=01; ALUSrcA=11 for LUI, 01 for AUIPC; next ALUWB.
REQ-021 IMMSrc SHALL be 000 in FETCH, else decoded from op: load/JALR/ALU-imm 000, store 001, branch 010, LUI/AUIPC 011, JAL 100, others 000.
REQ-022 instr_done SHALL pulse 1 cycle in the final state of each instruction (MEMWB, MEMWRITE with mem_ready, ALUWB, BRANCH); not on illegal.
REQ-023 mem_ready in states other than FETCH/MEMREAD/MEMWRITE SHALL be ignored.

Reset
REQ-024 rst=1 SHALL force state=FETCH immediately and all outputs 0 while asserted.
REQ-025 rst asserted mid-instruction (e.g. MEMWRITE waiting) SHALL abort it; first post-reset cycle is a fresh FETCH.

Configuration
REQ-026 With SHAMT_IMM_EN defined, op 0010011 with funct3 001 or 101 SHALL drive IMMSrc=101; otherwise those drive 000; no other behaviour changes.

Verification
REQ-027 Reset in MEMREAD, then release -> state=0, MemRead=1 on first cycle, no RegWrite.
REQ-028 add (0x002081B3), mem_ready=1 -> states 0,1,6,8,0; RegWrite=1 and instr_done=1 in state 8 only.
REQ-029 lw (0x0000A183), mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, then MEMWB ResultSrc=01.
REQ-030 beq (0x00208463) zero=0 -> PCWrite=0 in BRANCH; zero=1 -> PCWrite=1; IMMSrc=010 in DECODE.
REQ-031 slli (0x00309093): IMMSrc=101 with SHAMT_IMM_EN, 000 without; op 0x7F -> illegal pulse, back to FETCH.
